// File: rtl/sseg_pkg.sv
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants, slot-phase type and helpers for the
//               seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    // What the output stage shows during the current cycle of a slot.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_GUARD = 2'd1,
        PH_LIT   = 2'd2,
        PH_BLANK = 2'd3
    } slot_phase_e;

    function automatic logic params_ok(
        input int num_digits,
        input int refresh_div,
        input int guard,
        input int cnt_w
    );
        return (num_digits >= 2) && (num_digits <= MAX_DIGITS) &&
               (guard >= 0) && (guard < refresh_div) &&
               ((longint'(1) << cnt_w) >= longint'(refresh_div));
    endfunction

    // A digit blanks only when it and every digit above it are zero with no
    // decimal point; digit 0 always stays lit so a zero value shows one "0".
    function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input logic [MAX_DIGITS-1:0]   dp,
        input logic                    blank_lz,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  above;
        mask  = '0;
        above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                above   = above && blank_lz && (value[4*i +: 4] == 4'h0) && !dp[i];
                mask[i] = above;
            end
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_7seg.sv
// ============================================================================
// Module      : led_7seg
// Description : Hex nibble to active-high {g,f,e,d,c,b,a} segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_7seg (
    input  logic       en,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (en) begin
            case (nibble)
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
// ============================================================================
// Module      : sseg_scan_ctrl
// Description : Multiplexed common-anode seven-segment scan controller with
//               frame-synchronous image updates and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [7:0]              sseg,
    output logic                    frame_done
);

    localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, GUARD, CNT_W)) begin : g_param_check
        $error("sseg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/GUARD/CNT_W combination");
    end

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_blz;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   blank_mask;

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        digit_idx;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic [MAX_DIGITS-1:0]   next_mask;
    slot_phase_e             phase;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_end  = enable && slot_end && (digit_idx == IDX_LAST);
    assign cur_nibble = act_value[{digit_idx, 2'b00} +: 4];

    assign next_mask = lz_blank_mask((4*MAX_DIGITS)'(pend_value),
                                     MAX_DIGITS'(pend_dp),
                                     pend_blz, NUM_DIGITS);

    led_7seg u_dec (
        .en     (1'b1),
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_comb begin
        phase = PH_LIT;
        if (!enable) begin
            phase = PH_IDLE;
        end else if (slot_cnt < GUARD_CNT) begin
            phase = PH_GUARD;
        end else if (blank_mask[digit_idx]) begin
            phase = PH_BLANK;
        end
    end

    // Host capture runs regardless of enable so a load made while the
    // display is off is still applied once scanning resumes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blz   <= 1'b0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            blank_mask <= '0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_mask;
                pend_blz   <= blank_lz;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
            if (frame_end && pend_valid) begin
                act_value  <= pend_value;
                act_dp     <= pend_dp;
                blank_mask <= next_mask[NUM_DIGITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            digit_sel  <= SEL_OFF;
            sseg       <= SEG_OFF;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            case (phase)
                PH_LIT: begin
                    digit_sel <= ~(NUM_DIGITS'(1) << digit_idx);
                    sseg      <= {~act_dp[digit_idx], ~cur_seg};
                end
                default: begin
                    digit_sel <= SEL_OFF;
                    sseg      <= SEG_OFF;
                end
            endcase

            frame_done <= frame_end;
            load_ack   <= frame_end && pend_valid;

            if (!enable) begin
                slot_cnt  <= '0;
                digit_idx <= '0;
            end else if (slot_end) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
